// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus as seen between the core (master) and a
// memory-side responder (slave).
//
// Handshake: the master raises mem_valid with mem_instr/mem_addr/mem_wdata/
// mem_wstrb and holds all of them stable until the slave pulses mem_ready
// for one cycle. mem_rdata is only meaningful in that mem_ready cycle.
// mem_wstrb == 0 means a read. mem_valid may stay high in the cycle after
// mem_ready to start the next transfer.
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the PicoRV32 native memory interface.
// Accepts one request at a time, waits WAIT_CYCLES (plus any stall cycles),
// then answers with a one-cycle mem_ready. Backed by a MEM_WORDS x 32 array
// that survives reset. Initiator protocol violations latch proto_err.
// The array has no reset and no clear path; it relies on the power-up
// zero state of the storage (bitstream init on FPGA, zero-init in sim).
module picorv32_mem_responder #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    picorv32_mem_responder_if.slave        bus,
    input  logic                           stall,
    output logic                           proto_err,
    output logic                           oor,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;

    // Request fields captured at acceptance
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    // Registered outputs
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        oor_q;
    logic        perr_q;

    // Fields of the request that will be answered in the next RESP cycle.
    // With zero wait states the request goes straight from IDLE to RESP, so
    // the live bus is used before it lands in the capture registers.
    logic [29:0] resp_word;
    logic [3:0]  resp_wstrb;
    logic        resp_in_range;
    logic        err_d;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [29:0] word);
        return {2'b00, word} < 32'(MEM_WORDS);
    endfunction

    // Next-state, wait counter and protocol-violation detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES != 0 || stall) ? S_WAIT : S_RESP;
                    if (bus.mem_addr[1:0] != 2'b00 ||
                        (bus.mem_instr && bus.mem_wstrb != 4'd0))
                        err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!stall) begin
                    if (cnt_q <= 4'd1)
                        state_d = S_RESP;
                    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                end
                if (!bus.mem_valid)
                    err_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A held request must not change its fields while it is being served;
        // once mem_valid is low the fields are don't-care.
        if ((state_q == S_WAIT || state_q == S_RESP) && bus.mem_valid &&
            (bus.mem_addr != addr_q || bus.mem_wdata != wdata_q ||
             bus.mem_wstrb != wstrb_q || bus.mem_instr != instr_q))
            err_d = 1'b1;
        resp_word     = capture ? bus.mem_addr[31:2] : addr_q[31:2];
        resp_wstrb    = capture ? bus.mem_wstrb : wstrb_q;
        resp_in_range = in_range(resp_word);
    end

    // State, counter, capture registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            instr_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            oor_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
                instr_q <= bus.mem_instr;
            end
            ready_q <= (state_d == S_RESP);
            oor_q   <= (state_d == S_RESP) && !resp_in_range;
            if (state_d == S_RESP && resp_wstrb == 4'd0 && resp_in_range)
                rdata_q <= mem[resp_word[IDX_W-1:0]];
            else
                rdata_q <= 32'd0;
            perr_q  <= perr_q | err_d;
        end
    end

    // Byte-masked array write on the edge that leaves RESP
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && wstrb_q != 4'd0 && in_range(addr_q[31:2])) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i])
                    mem[addr_q[IDX_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign oor           = oor_q;
    assign proto_err     = perr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Self-checking bench for picorv32_mem_responder: directed scenarios with
// literal expectations plus randomized traffic checked every cycle against
// a transaction-level model of the responder.
module tb_picorv32_mem_responder;

    localparam int W     = 1;
    localparam int WORDS = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       proto_err;
    logic       oor;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    picorv32_mem_responder_if bus();

    picorv32_mem_responder #(.MEM_WORDS(WORDS), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall     (stall),
        .proto_err (proto_err),
        .oor       (oor),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: a request is accepted when the responder is free,
    // it then needs a number of stall-free cycles before its answer appears,
    // the answer is visible for one cycle and the write lands when that
    // cycle ends.
    bit [31:0] exp_mem [WORDS];
    bit        m_busy, m_resp;
    int        m_need;
    bit [31:0] c_addr, c_wdata;
    bit [3:0]  c_wstrb;
    bit        c_instr;
    bit        m_ready, m_oor, m_perr;
    bit [31:0] m_rdata;

    task automatic model_respond();
        m_resp  = 1'b1;
        m_ready = 1'b1;
        m_oor   = (c_addr[31:2] >= 30'(WORDS));
        m_rdata = (c_wstrb == 4'd0 && !m_oor) ? exp_mem[c_addr[31:2]] : 32'd0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_resp = 0; m_need = 0;
            m_ready = 0; m_oor = 0; m_perr = 0; m_rdata = 0;
        end else begin
            if (m_busy && !m_resp && !bus.mem_valid)
                m_perr = 1'b1;
            if (m_busy && bus.mem_valid &&
                (bus.mem_addr != c_addr || bus.mem_wdata != c_wdata ||
                 bus.mem_wstrb != c_wstrb || bus.mem_instr != c_instr))
                m_perr = 1'b1;
            m_ready = 0; m_oor = 0; m_rdata = 0;
            if (m_resp) begin
                if (c_wstrb != 4'd0 && c_addr[31:2] < 30'(WORDS)) begin
                    for (int i = 0; i < 4; i++)
                        if (c_wstrb[i])
                            exp_mem[c_addr[31:2]][8*i +: 8] = c_wdata[8*i +: 8];
                end
                m_busy = 0;
                m_resp = 0;
            end else if (m_busy) begin
                if (!stall) begin
                    m_need--;
                    if (m_need <= 0) model_respond();
                end
            end else if (bus.mem_valid) begin
                if (bus.mem_addr[1:0] != 2'b00 || (bus.mem_instr && bus.mem_wstrb != 4'd0))
                    m_perr = 1'b1;
                c_addr  = bus.mem_addr;
                c_wdata = bus.mem_wdata;
                c_wstrb = bus.mem_wstrb;
                c_instr = bus.mem_instr;
                m_busy  = 1'b1;
                m_need  = (W == 0 && stall) ? 1 : W;
                if (m_need == 0) model_respond();
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("ready", 32'(bus.mem_ready), 32'(m_ready));
            chk("oor", 32'(oor), 32'(m_oor));
            chk("proto_err", 32'(proto_err), 32'(m_perr));
            if (m_ready)
                chk("rdata", bus.mem_rdata, m_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge. mutate: 1 = bump address in WAIT, 2 = drop valid in WAIT.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr,
                        input int nstall, input bit rnd_stall, input int mutate,
                        output logic [31:0] rdata, output int lat, output bit oor_seen);
        int n0;
        int k;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        bus.mem_instr = instr;
        stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        n0 = cyc;
        k = 0;
        lat = -1;
        rdata = 32'd0;
        oor_seen = 1'b0;
        while (k < 64) begin
            @(negedge clk);
            k++;
            if (bus.mem_ready) begin
                rdata = bus.mem_rdata;
                oor_seen = oor;
                lat = cyc - n0;
                break;
            end
            stall = rnd_stall ? ($urandom_range(0, 3) == 0) : (k <= nstall);
            if (k == 1 && mutate == 1) bus.mem_addr = addr + 32'd4;
            if (k == 1 && mutate == 2) bus.mem_valid = 1'b0;
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: no mem_ready within 64 cycles for addr %h", addr);
        end
        @(negedge clk);
        bus.mem_valid = 1'b0;
        stall = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        bit          os;
        logic [29:0] word;
        logic [3:0]  strb;
        logic        instr;
        int          gap;

        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_oor", 32'(oor), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Basic write/read with fixed latency
        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("wr_latency", 32'(lat), 32'd2);
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);

        // Byte strobe merge
        xfer(32'h10, 32'h00001200, 4'b0010, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("strb_wr_rdata", rd, 32'd0);
        xfer(32'h10, 32'h0, 4'h0, 1'b1, 0, 1'b0, 0, rd, lat, os);
        chk("strb_merge", rd, 32'hDEAD12EF);

        // Three stall cycles in WAIT
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 3, 1'b0, 0, rd, lat, os);
        chk("stall_latency", 32'(lat), 32'd5);
        chk("stall_data", rd, 32'hDEAD12EF);
        chk("stall_no_err", 32'(proto_err), 32'd0);

        // Out of range read, one-cycle oor pulse
        xfer(32'h400, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("oor_rdata", rd, 32'd0);
        chk("oor_pulse", 32'(os), 32'd1);
        chk("oor_cleared", 32'(oor), 32'd0);
        xfer(32'h400, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("oor_wr_pulse", 32'(os), 32'd1);
        xfer(32'h0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("oor_wr_dropped", rd, 32'd0);

        // Misaligned read: flagged, served from word 0x10
        xfer(32'h12, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("misaligned_data", rd, 32'hDEAD12EF);
        chk("misaligned_err", 32'(proto_err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(proto_err), 32'd0);

        // Address changes in WAIT: error is sticky across later clean traffic
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1, rd, lat, os);
        chk("addr_change_data", rd, 32'hDEAD12EF);
        chk("addr_change_err", 32'(proto_err), 32'd1);
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("err_sticky", 32'(proto_err), 32'd1);
        do_reset();
        chk("err_cleared2", 32'(proto_err), 32'd0);

        // mem_valid dropped in WAIT
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b0, 2, rd, lat, os);
        chk("valid_drop_err", 32'(proto_err), 32'd1);
        do_reset();

        // Instruction fetch carrying write strobes
        xfer(32'h30, 32'h55AA55AA, 4'hF, 1'b1, 0, 1'b0, 0, rd, lat, os);
        chk("instr_wstrb_err", 32'(proto_err), 32'd1);
        do_reset();
        xfer(32'h30, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("instr_wstrb_wr", rd, 32'h55AA55AA);

        // Reset in the middle of a write aborts it
        xfer(32'h20, 32'h11223344, 4'hF, 1'b0, 0, 1'b0, 0, rd, lat, os);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h20;
        bus.mem_wdata = 32'hFFFFFFFF;
        bus.mem_wstrb = 4'hF;
        bus.mem_instr = 1'b0;
        @(negedge clk);
        chk("mid_wait_state", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.mem_ready), 32'd0);
        chk("abort_rdata", bus.mem_rdata, 32'd0);
        chk("abort_proto_err", 32'(proto_err), 32'd0);
        chk("abort_oor", 32'(oor), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        xfer(32'h20, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rd, lat, os);
        chk("abort_no_write", rd, 32'h11223344);

        // Randomized traffic, protocol-clean, checked by the per-cycle compare
        for (int t = 0; t < 300; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 9) == 0)
                word = 30'(WORDS + $urandom_range(0, 3));
            else
                word = 30'($urandom_range(0, 15));
            strb  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            instr = (strb == 4'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer({word, 2'b00}, $urandom, strb, instr, 0, 1'b1, 0, rd, lat, os);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
